// File: rtl/gsim_pkg.sv
// Shared constants, address split and state encoding for the Gauss-Seidel
// result path; the address helpers mirror the solver's o_x_addr layout.
package gsim_pkg;

  localparam int DATA_W      = 32;
  localparam int LANES       = 8;
  localparam int MAT_W       = 5;
  localparam int IDX_W       = 4;
  localparam int LANE_W      = 3;
  localparam int ADDR_W      = MAT_W + IDX_W;
  localparam int BEAT_ADDR_W = MAT_W + 1;
  localparam int BEAT_W      = DATA_W * LANES;
  localparam int FIFO_DEPTH  = 2;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE    = 2'd0;
  localparam state_t S_COLLECT = 2'd1;
  localparam state_t S_DRAIN   = 2'd2;
  localparam state_t S_DONE    = 2'd3;

  typedef struct packed {
    logic [BEAT_ADDR_W-1:0] addr;
    logic [BEAT_W-1:0]      data;
  } beat_t;

  function automatic logic [MAT_W-1:0] addr_mat(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: MAT_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[IDX_W-1:0];
  endfunction

  function automatic logic [LANE_W-1:0] addr_lane(input logic [ADDR_W-1:0] a);
    return a[LANE_W-1:0];
  endfunction

  // Beat address is the matrix plus which half (idx[3]) of its 16 values.
  function automatic logic [BEAT_ADDR_W-1:0] beat_tag(input logic [ADDR_W-1:0] a);
    logic [IDX_W-1:0] idx;
    idx = addr_idx(a);
    return {addr_mat(a), idx[IDX_W-1]};
  endfunction

endpackage

// File: rtl/gsim_x_packer_if.sv
// Wide result-memory write bus: one 256-bit beat per transfer on a
// valid/ready handshake.
interface gsim_x_packer_if;
  logic                               o_wr_vld;
  logic                               i_wr_rdy;
  logic [gsim_pkg::BEAT_ADDR_W-1:0]   o_wr_addr;
  logic [gsim_pkg::BEAT_W-1:0]        o_wr_data;

  modport master (output o_wr_vld, output o_wr_addr, output o_wr_data, input i_wr_rdy);
  modport slave  (input o_wr_vld, input o_wr_addr, input o_wr_data, output i_wr_rdy);
endinterface

// File: rtl/gsim_beat_fifo.sv
// Two-entry beat buffer; head is a register so the output beat is held
// stable while the sink stalls. A full buffer accepts a push on a pop cycle.
module gsim_beat_fifo
  import gsim_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_reset,
  input  logic  i_push,
  input  beat_t i_din,
  input  logic  i_pop,
  output beat_t o_head,
  output logic  o_empty,
  output logic  o_full
);

  localparam logic [1:0] FULL_CNT = 2'(FIFO_DEPTH);

  logic [1:0] count_q, count_d;
  beat_t      head_q, head_d;
  beat_t      tail_q, tail_d;
  logic       pop_ok_s, push_ok_s;

  // next-entry selection for every push/pop combination
  always_comb begin
    count_d   = count_q;
    head_d    = head_q;
    tail_d    = tail_q;
    pop_ok_s  = i_pop && (count_q != 2'd0);
    push_ok_s = i_push && ((count_q != FULL_CNT) || pop_ok_s);
    case ({push_ok_s, pop_ok_s})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d = i_din;
        end else begin
          tail_d = i_din;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = i_din;
        end else begin
          head_d = tail_q;
          tail_d = i_din;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign o_head  = head_q;
  assign o_empty = (count_q == 2'd0);
  assign o_full  = (count_q == FULL_CNT);

endmodule

// File: rtl/gsim_x_packer.sv
// Collects the solver's x writes into 8-lane beats, buffers them toward the
// result memory, and tracks ordering, overflow and end-of-job drain.
module gsim_x_packer
  import gsim_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_x_wen,
  input  logic [ADDR_W-1:0]    i_x_addr,
  input  logic [DATA_W-1:0]    i_x_data,
  input  logic                 i_proc_done,
  gsim_x_packer_if.master      wr_if,
  output logic                 o_all_written,
  output logic                 o_err_order,
  output logic                 o_overflow
);

  state_t                         state_q, state_d;
  logic [ADDR_W-1:0]              exp_q, exp_d;
  logic [LANES-1:0][DATA_W-1:0]   stage_q, stage_d;
  logic [LANES-1:0]               mask_q, mask_d;
  logic [BEAT_ADDR_W-1:0]         tag_q, tag_d;
  logic                           err_q, err_d;
  logic                           ovf_q, ovf_d;
  logic                           allw_q, allw_d;

  logic [LANES-1:0][DATA_W-1:0]   merge_lanes_s;
  logic [LANES-1:0]               merge_mask_s;
  logic [BEAT_ADDR_W-1:0]         merge_tag_s;
  logic                           accept_s, lane7_s, flush_s;
  logic                           push_s, pop_s;
  beat_t                          push_beat_s;
  beat_t                          head_s;
  logic                           fifo_empty_s, fifo_full_s;

  assign pop_s = wr_if.i_wr_rdy && !fifo_empty_s;

  // capture, beat assembly, flags and job sequencing
  always_comb begin
    state_d       = state_q;
    exp_d         = exp_q;
    stage_d       = stage_q;
    mask_d        = mask_q;
    tag_d         = tag_q;
    err_d         = err_q;
    ovf_d         = ovf_q;
    push_s        = 1'b0;
    push_beat_s   = '0;
    merge_lanes_s = stage_q;
    merge_mask_s  = mask_q;
    merge_tag_s   = tag_q;
    accept_s      = i_x_wen && ((state_q == S_IDLE) || (state_q == S_COLLECT));

    // Out-of-order data is still stored at its own lane; only the flag records it.
    if (accept_s) begin
      merge_lanes_s[addr_lane(i_x_addr)] = i_x_data;
      merge_mask_s[addr_lane(i_x_addr)]  = 1'b1;
      merge_tag_s                        = beat_tag(i_x_addr);
      exp_d                              = i_x_addr + ADDR_W'(1);
      if (i_x_addr != exp_q) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end else begin
      exp_d = exp_q;
    end

    lane7_s = accept_s && (addr_lane(i_x_addr) == 3'd7);
    flush_s = (state_q == S_COLLECT) && i_proc_done && !lane7_s && (merge_mask_s != '0);

    push_beat_s.addr = merge_tag_s;
    for (int k = 0; k < LANES; k++) begin
      push_beat_s.data[k*DATA_W +: DATA_W] = merge_mask_s[k] ? merge_lanes_s[k] : '0;
    end

    tag_d = merge_tag_s;
    if (lane7_s || flush_s) begin
      push_s  = 1'b1;
      stage_d = '0;
      mask_d  = '0;
    end else begin
      stage_d = merge_lanes_s;
      mask_d  = merge_mask_s;
    end

    if (flush_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_d;
    end

    if (push_s && fifo_full_s && !pop_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_d;
    end

    case (state_q)
      S_IDLE: begin
        if (i_x_wen) begin
          state_d = S_COLLECT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COLLECT: begin
        if (i_proc_done) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_DRAIN: begin
        if (fifo_empty_s && !push_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        if (!i_proc_done) begin
          state_d = S_IDLE;
          exp_d   = '0;
          err_d   = 1'b0;
          ovf_d   = 1'b0;
          stage_d = '0;
          mask_d  = '0;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    allw_d = (state_d == S_DONE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      exp_q   <= '0;
      stage_q <= '0;
      mask_q  <= '0;
      tag_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      allw_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      stage_q <= stage_d;
      mask_q  <= mask_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      allw_q  <= allw_d;
    end
  end

  gsim_beat_fifo u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (push_s),
    .i_din   (push_beat_s),
    .i_pop   (pop_s),
    .o_head  (head_s),
    .o_empty (fifo_empty_s),
    .o_full  (fifo_full_s)
  );

  assign wr_if.o_wr_vld  = !fifo_empty_s;
  assign wr_if.o_wr_addr = head_s.addr;
  assign wr_if.o_wr_data = head_s.data;
  assign o_all_written   = allw_q;
  assign o_err_order     = err_q;
  assign o_overflow      = ovf_q;

endmodule

// File: tb/tb_gsim_x_packer.sv
// Directed and randomized bench for gsim_x_packer against a queue-based
// reference model of the packing, buffering and flag rules.
`timescale 1ns/1ps
module tb_gsim_x_packer;

  localparam int M_IDLE    = 0;
  localparam int M_COLLECT = 1;
  localparam int M_DRAIN   = 2;
  localparam int M_DONE    = 3;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_x_wen = 1'b0;
  logic [8:0]  i_x_addr = 9'd0;
  logic [31:0] i_x_data = 32'd0;
  logic        i_proc_done = 1'b0;
  logic        o_all_written, o_err_order, o_overflow;

  gsim_x_packer_if wr_bus();

  gsim_x_packer dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_x_wen       (i_x_wen),
    .i_x_addr      (i_x_addr),
    .i_x_data      (i_x_data),
    .i_proc_done   (i_proc_done),
    .wr_if         (wr_bus),
    .o_all_written (o_all_written),
    .o_err_order   (o_err_order),
    .o_overflow    (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [5:0]   addr;
    logic [255:0] data;
  } mbeat_t;

  mbeat_t      m_q[$];
  int          m_st;
  int          m_exp;
  logic [31:0] m_lane[8];
  bit          m_has[8];
  logic [5:0]  m_tag;
  bit          m_err, m_ovf, m_allw;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_st = M_IDLE; m_exp = 0; m_tag = 6'd0;
    m_err = 0; m_ovf = 0; m_allw = 0;
    for (int k = 0; k < 8; k++) begin m_lane[k] = 32'd0; m_has[k] = 0; end
  endtask

  // one clock edge of the reference: inputs are those present at the edge
  task automatic model_edge();
    bit pop, push, any;
    mbeat_t nb;
    int nst, lane, pre, a;
    pre  = m_q.size();
    pop  = (pre > 0) && wr_bus.i_wr_rdy;
    push = 0;
    nst  = m_st;
    nb   = '0;
    if (i_x_wen && (m_st == M_IDLE || m_st == M_COLLECT)) begin
      a = int'(i_x_addr);
      if (a != m_exp) m_err = 1;
      m_exp = (a + 1) % 512;
      lane = a % 8;
      m_lane[lane] = i_x_data;
      m_has[lane] = 1;
      m_tag = 6'(a / 8);
      if (lane == 7) push = 1;
      if (m_st == M_IDLE) nst = M_COLLECT;
    end
    any = 0;
    for (int k = 0; k < 8; k++) any = any | m_has[k];
    if (m_st == M_COLLECT && i_proc_done && !push && any) begin
      push = 1;
      m_err = 1;
    end
    if (push) begin
      nb.addr = m_tag;
      for (int k = 0; k < 8; k++) begin
        nb.data[k*32 +: 32] = m_has[k] ? m_lane[k] : 32'd0;
        m_has[k] = 0;
        m_lane[k] = 32'd0;
      end
    end
    if (m_st == M_COLLECT && i_proc_done) nst = M_DRAIN;
    if (m_st == M_DRAIN && pre == 0) nst = M_DONE;
    if (m_st == M_DONE && !i_proc_done) begin
      nst = M_IDLE; m_exp = 0; m_err = 0; m_ovf = 0;
    end
    if (pop) m_q.delete(0);
    if (push) begin
      if (pre == 2 && !pop) m_ovf = 1;
      else m_q.push_back(nb);
    end
    m_st = nst;
    m_allw = (m_st == M_DONE);
  endtask

  task automatic step();
    @(posedge i_clk);
    model_edge();
    #1;
    chk("wr_vld", wr_bus.o_wr_vld, m_q.size() > 0);
    if (m_q.size() > 0) begin
      chk("wr_addr", wr_bus.o_wr_addr, m_q[0].addr);
      chk("wr_data", wr_bus.o_wr_data, m_q[0].data);
    end
    chk("err_order", o_err_order, m_err);
    chk("overflow", o_overflow, m_ovf);
    chk("all_written", o_all_written, m_allw);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    i_x_wen = 1'b1; i_x_addr = 9'(a); i_x_data = d;
    step();
    i_x_wen = 1'b0;
    step();
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    #1;
    chk("rst_vld", wr_bus.o_wr_vld, 1'b0);
    chk("rst_err", o_err_order, 1'b0);
    chk("rst_ovf", o_overflow, 1'b0);
    chk("rst_allw", o_all_written, 1'b0);
    model_reset();
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
  endtask

  task automatic finish_job();
    i_proc_done = 1'b1;
    wr_bus.i_wr_rdy = 1'b1;
    for (int i = 0; i < 40 && m_st != M_DONE; i++) step();
    chk("job_all_written", o_all_written, 1'b1);
    step();
    i_proc_done = 1'b0;
    step();
    step();
    chk("job_flags_clear", {o_err_order, o_overflow, o_all_written}, 3'b000);
  endtask

  initial begin
    wr_bus.i_wr_rdy = 1'b0;
    model_reset();
    do_reset();
    step();

    // in-order matrix 0 with sink always ready
    wr_bus.i_wr_rdy = 1'b1;
    for (int idx = 0; idx < 16; idx++) begin
      i_x_wen = 1'b1; i_x_addr = 9'(idx); i_x_data = 32'h0001_0000 + 32'(idx);
      step();
      if (idx == 7) begin
        chk("t1_addr0", wr_bus.o_wr_addr, 6'd0);
        chk("t1_lane0", wr_bus.o_wr_data[31:0], 32'h0001_0000);
        chk("t1_lane7", wr_bus.o_wr_data[255:224], 32'h0001_0007);
      end
      if (idx == 15) chk("t1_addr1", wr_bus.o_wr_addr, 6'd1);
      i_x_wen = 1'b0;
      step();
    end
    chk("t1_err", o_err_order, 1'b0);
    finish_job();

    // two matrices with sink stalled: third beat dropped
    wr_bus.i_wr_rdy = 1'b0;
    for (int a = 0; a < 32; a++) wr(a, $urandom);
    chk("t2_ovf", o_overflow, 1'b1);
    wr_bus.i_wr_rdy = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("t2_drained", wr_bus.o_wr_vld, 1'b0);
    finish_job();

    // full buffer, lane-7 push coincides with a pop
    wr_bus.i_wr_rdy = 1'b0;
    for (int a = 0; a < 23; a++) wr(a, $urandom);
    i_x_wen = 1'b1; i_x_addr = 9'd23; i_x_data = $urandom; wr_bus.i_wr_rdy = 1'b1;
    step();
    i_x_wen = 1'b0;
    step();
    chk("t3_no_ovf", o_overflow, 1'b0);
    for (int i = 0; i < 3; i++) step();
    finish_job();

    // idx 2 skipped
    for (int a = 0; a < 8; a++) if (a != 2) wr(a, $urandom);
    chk("t4_err", o_err_order, 1'b1);
    finish_job();

    // partial beat flushed at done
    for (int a = 0; a < 11; a++) wr(a, $urandom);
    finish_job();

    // randomized jobs with random sink backpressure
    for (int job = 0; job < 5; job++) begin
      int a, n;
      a = 0;
      n = $urandom_range(40, 5);
      for (int w = 0; w < n; w++) begin
        if ($urandom_range(7, 0) == 0) a = (a + 1) % 512;
        wr_bus.i_wr_rdy = ($urandom_range(3, 0) != 0);
        i_x_wen = 1'b1; i_x_addr = 9'(a); i_x_data = $urandom;
        step();
        i_x_wen = 1'b0;
        wr_bus.i_wr_rdy = ($urandom_range(3, 0) != 0);
        step();
        a = (a + 1) % 512;
      end
      finish_job();
    end

    // reset while a beat is held and flags are set
    wr_bus.i_wr_rdy = 1'b0;
    for (int a = 1; a < 25; a++) wr(a, $urandom);
    chk("t7_pre_ovf", o_overflow, 1'b1);
    chk("t7_pre_vld", wr_bus.o_wr_vld, 1'b1);
    do_reset();
    step();
    wr_bus.i_wr_rdy = 1'b1;
    for (int a = 0; a < 8; a++) wr(a, $urandom);
    chk("t7_post_err", o_err_order, 1'b0);
    finish_job();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
